vxc_add_seq: RTL and testbench

Chunk sequencer directly upstream of the 8-lane scaled-vector add/subtract unit (`vXc_add_8`, result = y ± c·x). It walks two NOE-element vectors stored NI elements per word, issues one chunk per cycle into the datapath, and zero-masks the tail lanes beyond NOE. It tracks the fixed datapath latency and writes each returned result word back to the result memory. It also reports completion, replacing the free-running finish counter as the system's done source.

---
 rtl/vxc_pkg.sv | 35 +++
 rtl/vxc_valid_pipe.sv | 39 +++
 rtl/vxc_add_seq.sv | 143 ++++++++++++++
 tb/tb_vxc_add_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vxc_pkg.sv
// Shared types and helpers for the vxc_add_seq chunk sequencer.
package vxc_pkg;

    localparam int ELEMENT_WIDTH = 32;
    localparam int NI            = 8;
    localparam int ADDR_W        = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] chunk;
        logic [NI-1:0]     mask;
    } pipe_entry_t;

    function automatic int chunk_count(input int noe);
        return (noe + NI - 1) / NI;
    endfunction

    // Lane 0 sits in the MSBs of a word, so its enable is the top mask bit.
    function automatic logic [NI-1:0] lane_mask(input int k, input int noe);
        logic [NI-1:0] m;
        m = '0;
        for (int j = 0; j < NI; j++) begin
            if (k * NI + j < noe) m[NI-1-j] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/vxc_valid_pipe.sv
// Shift register of in-flight chunk entries, cleared synchronously.
module vxc_valid_pipe
    import vxc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  pipe_entry_t   din,
    output logic          head_valid,
    output logic [NI-1:0] head_mask,
    output pipe_entry_t   tail,
    output logic          pre_tail_valid,
    output logic          pending
);

    pipe_entry_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else begin
            stage[0] <= din;
            for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
    end

    assign head_valid     = stage[0].valid;
    assign head_mask      = stage[0].mask;
    assign tail           = stage[DEPTH-1];
    assign pre_tail_valid = stage[DEPTH-2].valid;

    // Anything still ahead of the output stage.
    always_comb begin
        pending = 1'b0;
        for (int s = 0; s < DEPTH - 1; s++) pending = pending | stage[s].valid;
    end

endmodule

// File: rtl/vxc_add_seq.sv
// Chunk sequencer feeding the 8-lane y +/- c*x datapath; writes results back.
// Define VXC_SEQ_TAIL_MASK_EN to zero tail lanes and mask their writes.
module vxc_add_seq
    import vxc_pkg::*;
#(
    parameter int NOE     = 16,
    parameter int LATENCY = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        op,
    input  logic [ELEMENT_WIDTH-1:0]    constant,
    output logic                        busy,
    output logic                        done,
    output logic                        rd_en,
    output logic [ADDR_W-1:0]           rd_addr,
    input  logic [NI*ELEMENT_WIDTH-1:0] x_rd_data,
    input  logic [NI*ELEMENT_WIDTH-1:0] y_rd_data,
    output logic [NI*ELEMENT_WIDTH-1:0] dp_first,
    output logic [NI*ELEMENT_WIDTH-1:0] dp_second,
    output logic [ELEMENT_WIDTH-1:0]    dp_constant,
    output logic                        dp_op,
    input  logic [NI*ELEMENT_WIDTH-1:0] dp_result,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [NI*ELEMENT_WIDTH-1:0] wr_data,
    output logic [NI-1:0]               wr_mask
);

    localparam int W      = NI * ELEMENT_WIDTH;
    localparam int CHUNKS = chunk_count(NOE);
    localparam int DEPTH  = LATENCY + 3;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CHUNKS - 1);

    state_t        state;
    pipe_entry_t   din;
    pipe_entry_t   tail;
    logic          head_valid;
    logic [NI-1:0] head_mask;
    logic          pre_tail_valid;
    logic          pending;
    logic [NI-1:0] rd_mask;
    logic [W-1:0]  lane_keep;

    always_comb begin
        rd_mask = '0;
        if (rd_en) begin
`ifdef VXC_SEQ_TAIL_MASK_EN
            rd_mask = lane_mask(int'(rd_addr), NOE);
`else
            rd_mask = '1;
`endif
        end
    end

    assign din = '{valid: rd_en, chunk: rd_addr, mask: rd_mask};

    vxc_valid_pipe #(
        .DEPTH (DEPTH)
    ) u_pipe (
        .clk            (clk),
        .clear          (reset),
        .din            (din),
        .head_valid     (head_valid),
        .head_mask      (head_mask),
        .tail           (tail),
        .pre_tail_valid (pre_tail_valid),
        .pending        (pending)
    );

    // Mask bit m covers data bits [m*EW +: EW].
    always_comb begin
        lane_keep = '0;
        for (int m = 0; m < NI; m++) begin
            lane_keep[m*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
                {ELEMENT_WIDTH{head_valid & head_mask[m]}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            dp_constant <= '0;
            dp_op       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ISSUE;
                        busy        <= 1'b1;
                        rd_en       <= 1'b1;
                        rd_addr     <= '0;
                        dp_op       <= op;
                        dp_constant <= constant;
                    end
                end
                ISSUE: begin
                    if (rd_addr == LAST) begin
                        state   <= DRAIN;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dp_first  <= '0;
            dp_second <= '0;
            wr_data   <= '0;
        end else begin
            dp_first  <= x_rd_data & lane_keep;
            dp_second <= y_rd_data & lane_keep;
            wr_data   <= pre_tail_valid ? dp_result : '0;
        end
    end

    assign wr_en   = tail.valid;
    assign wr_addr = tail.chunk;
    assign wr_mask = tail.mask;

endmodule

// File: tb/tb_vxc_add_seq.sv
// Bench for vxc_add_seq: two instances (full and partial last word) run side by side
// against memory and datapath models; expectations come from element arithmetic.
`timescale 1ns/1ps
module tb_vxc_add_seq;
    import vxc_pkg::*;

    localparam int W     = NI * ELEMENT_WIDTH;
    localparam int LAT   = 5;
    localparam int NOE_A = 16;
`ifdef VXC_SEQ_TAIL_MASK_EN
    localparam int NOE_B  = 20;
    localparam bit MASKED = 1'b1;
`else
    localparam int NOE_B  = 24;
    localparam bit MASKED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, op;
    logic [31:0] constant;

    logic              busy [2], done [2], rd_en [2], wr_en [2], dp_op [2];
    logic [ADDR_W-1:0] rd_addr [2], wr_addr [2];
    logic [W-1:0]      x_rd [2], y_rd [2], dp_first [2], dp_second [2];
    logic [W-1:0]      dp_result [2], wr_data [2];
    logic [31:0]       dp_constant [2];
    logic [NI-1:0]     wr_mask [2];
    logic [W-1:0]      dpp [2][LAT];

    int   xv [2][32];
    int   yv [2][32];
    int   cur_c;
    logic cur_op;
    bit   use_tbl;
    logic [31:0] tbl_lane;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        op;
        int          c;
        int          x;
        int          y;
        logic [31:0] exp_lane;
    } vec_t;

    vec_t tbl [4];

    always #5 clk = ~clk;

    vxc_add_seq #(.NOE(NOE_A), .LATENCY(LAT)) u_a (
        .clk(clk), .reset(reset), .start(start), .op(op), .constant(constant),
        .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .x_rd_data(x_rd[0]), .y_rd_data(y_rd[0]),
        .dp_first(dp_first[0]), .dp_second(dp_second[0]),
        .dp_constant(dp_constant[0]), .dp_op(dp_op[0]), .dp_result(dp_result[0]),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .wr_mask(wr_mask[0])
    );

    vxc_add_seq #(.NOE(NOE_B), .LATENCY(LAT)) u_b (
        .clk(clk), .reset(reset), .start(start), .op(op), .constant(constant),
        .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .x_rd_data(x_rd[1]), .y_rd_data(y_rd[1]),
        .dp_first(dp_first[1]), .dp_second(dp_second[1]),
        .dp_constant(dp_constant[1]), .dp_op(dp_op[1]), .dp_result(dp_result[1]),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .wr_mask(wr_mask[1])
    );

    // Exact float <-> integer conversion for small integer-valued elements.
    function automatic logic [31:0] i2f(input int v);
        int a, p;
        logic [31:0] r;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        p = 0;
        while ((a >> (p + 1)) != 0) p++;
        r[31]    = (v < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'((a << (23 - p)) & 32'h7fffff);
        return r;
    endfunction

    function automatic int f2i(input logic [31:0] f);
        int p, m;
        if (f[30:23] == 8'd0) return 0;
        p = int'(f[30:23]) - 127;
        m = int'({8'd0, 1'b1, f[22:0]}) >> (23 - p);
        return f[31] ? -m : m;
    endfunction

    function automatic int noe_of(input int u);
        return (u == 0) ? NOE_A : NOE_B;
    endfunction

    function automatic int chunks(input int u);
        return (noe_of(u) + NI - 1) / NI;
    endfunction

    function automatic logic [W-1:0] raw_word(input int u, input int k, input bit sel);
        logic [W-1:0] w;
        int i;
        w = '0;
        for (int j = 0; j < NI; j++) begin
            i = k * NI + j;
            if (i < 32) w[W-1-32*j -: 32] = i2f(sel ? yv[u][i] : xv[u][i]);
        end
        return w;
    endfunction

    function automatic bit lane_live(input int u, input int i);
        return !MASKED || (i < noe_of(u));
    endfunction

    function automatic logic [W-1:0] in_word(input int u, input int k, input bit sel);
        logic [W-1:0] w;
        int i;
        w = '0;
        for (int j = 0; j < NI; j++) begin
            i = k * NI + j;
            if (lane_live(u, i))
                w[W-1-32*j -: 32] = i2f(sel ? yv[u][i] : xv[u][i]);
        end
        return w;
    endfunction

    function automatic logic [W-1:0] res_word(input int u, input int k);
        logic [W-1:0] w;
        int i, r;
        w = '0;
        for (int j = 0; j < NI; j++) begin
            i = k * NI + j;
            r = cur_op ? yv[u][i] - cur_c * xv[u][i] : yv[u][i] + cur_c * xv[u][i];
            if (lane_live(u, i)) w[W-1-32*j -: 32] = use_tbl ? tbl_lane : i2f(r);
        end
        return w;
    endfunction

    function automatic logic [NI-1:0] exp_mask(input int u, input int k);
        logic [NI-1:0] m;
        m = '0;
        for (int j = 0; j < NI; j++) if (lane_live(u, k * NI + j)) m[NI-1-j] = 1'b1;
        return m;
    endfunction

    // Model of the downstream datapath: fixed latency, lane-wise y +/- c*x.
    function automatic logic [W-1:0] dp_fn(input logic [W-1:0] f, input logic [W-1:0] s,
                                           input logic [31:0] c, input logic o);
        logic [W-1:0] w;
        int xi, yi, ci;
        ci = f2i(c);
        for (int j = 0; j < NI; j++) begin
            xi = f2i(f[W-1-32*j -: 32]);
            yi = f2i(s[W-1-32*j -: 32]);
            w[W-1-32*j -: 32] = i2f(o ? yi - ci * xi : yi + ci * xi);
        end
        return w;
    endfunction

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rd_en[u]) begin
                x_rd[u] <= raw_word(u, int'(rd_addr[u]), 1'b0);
                y_rd[u] <= raw_word(u, int'(rd_addr[u]), 1'b1);
            end
            dpp[u][0] <= dp_fn(dp_first[u], dp_second[u], dp_constant[u], dp_op[u]);
            for (int s = 1; s < LAT; s++) dpp[u][s] <= dpp[u][s-1];
        end
    end

    assign dp_result[0] = dpp[0][LAT-1];
    assign dp_result[1] = dpp[1][LAT-1];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int u, input string tag);
        chk($sformatf("%s u%0d", tag, u),
            W'(|{busy[u], done[u], rd_en[u], rd_addr[u], dp_first[u], dp_second[u],
                 dp_constant[u], dp_op[u], wr_en[u], wr_addr[u], wr_data[u], wr_mask[u]}),
            '0);
    endtask

    task automatic check_cycle(input int u, input int n, input bit aborted);
        int c, k;
        string t;
        c = chunks(u);
        t = $sformatf("u%0d n%0d", u, n);
        if (aborted) begin
            check_idle(u, $sformatf("abort_zero n%0d", n));
            return;
        end
        chk({"busy ", t}, W'(busy[u]), W'(n <= 9 + c));
        chk({"rd_en ", t}, W'(rd_en[u]), W'(n <= c));
        chk({"done ", t}, W'(done[u]), W'(n == 9 + c));
        chk({"wr_en ", t}, W'(wr_en[u]), W'(n >= 9 && n < 9 + c));
        if (n <= c) chk({"rd_addr ", t}, W'(rd_addr[u]), W'(n - 1));
        if (n == 1) begin
            chk({"dp_op ", t}, W'(dp_op[u]), W'(cur_op));
            chk({"dp_constant ", t}, W'(dp_constant[u]), W'(i2f(cur_c)));
        end
        if (n >= 3 && n < 3 + c) begin
            k = n - 3;
            chk({"dp_first ", t}, dp_first[u], in_word(u, k, 1'b0));
            chk({"dp_second ", t}, dp_second[u], in_word(u, k, 1'b1));
        end
        if (n >= 9 && n < 9 + c) begin
            k = n - 9;
            chk({"wr_addr ", t}, W'(wr_addr[u]), W'(k));
            chk({"wr_mask ", t}, W'(wr_mask[u]), W'(exp_mask(u, k)));
            chk({"wr_data ", t}, wr_data[u], res_word(u, k));
        end
    endtask

    task automatic run(input int glitch_at, input int reset_at, input int ncyc);
        op       = cur_op;
        constant = i2f(cur_c);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            start = (n == glitch_at);
            reset = (n == reset_at);
            for (int u = 0; u < 2; u++) check_cycle(u, n, reset_at > 0 && n > reset_at);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic fill_const(input int x, input int y);
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 32; i++) begin
                xv[u][i] = x;
                yv[u][i] = y;
            end
    endtask

    task automatic fill_rand();
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 32; i++) begin
                xv[u][i] = int'($urandom_range(0, 255));
                yv[u][i] = int'($urandom_range(0, 255));
            end
    endtask

    initial begin
        tbl[0] = '{1'b0, 2, 1, 3, 32'h40A00000};
        tbl[1] = '{1'b1, 2, 1, 3, 32'h3F800000};
        tbl[2] = '{1'b1, 3, 2, 1, 32'hC0A00000};
        tbl[3] = '{1'b0, 0, 7, 6, 32'h40C00000};

        for (int u = 0; u < 2; u++) begin
            x_rd[u] = '0;
            y_rd[u] = '0;
            for (int s = 0; s < LAT; s++) dpp[u][s] = '0;
        end
        reset    = 1'b1;
        start    = 1'b0;
        op       = 1'b0;
        constant = '0;
        use_tbl  = 1'b0;
        tbl_lane = '0;
        cur_c    = 0;
        cur_op   = 1'b0;
        fill_const(0, 0);
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) check_idle(u, "reset_state");
        reset = 1'b0;

        use_tbl = 1'b1;
        for (int r = 0; r < 4; r++) begin
            cur_op   = tbl[r].op;
            cur_c    = tbl[r].c;
            tbl_lane = tbl[r].exp_lane;
            fill_const(tbl[r].x, tbl[r].y);
            run(0, 0, 14);
        end
        use_tbl = 1'b0;

        for (int r = 0; r < 6; r++) begin
            cur_op = 1'($urandom_range(0, 1));
            cur_c  = int'($urandom_range(0, 7));
            fill_rand();
            run(0, 0, 14);
        end

        // Second start mid-run must be ignored.
        fill_rand();
        cur_op = 1'b0;
        cur_c  = 5;
        run(4, 0, 16);

        // Abort mid-run, then a clean rerun.
        cur_op = 1'b1;
        run(0, 6, 16);
        run(0, 0, 14);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("collide_busy u%0d n%0d", u, n), W'(busy[u]), '0);
                chk($sformatf("collide_rd_en u%0d n%0d", u, n), W'(rd_en[u]), '0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
